// File: rtl/serial_magnitude_comparator_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_magnitude_comparator_if
// Purpose  : Bundles the control, serial operand and result signals of the
//            serial magnitude comparator.
// Ports    : master - drives start, bit_valid, x_bit, y_bit; observes results
//            slave  - observes start, bit_valid, x_bit, y_bit; drives
//                     o_gt, o_eq, done, busy
// Revision : 1.0 - initial release
// ============================================================================
interface serial_magnitude_comparator_if;
  logic start;      // request a new comparison
  logic bit_valid;  // x_bit/y_bit carry an operand bit this cycle
  logic x_bit;      // operand x, MSB first
  logic y_bit;      // operand y, MSB first
  logic o_gt;       // registered x > y (unsigned)
  logic o_eq;       // registered x == y
  logic done;       // one-cycle pulse: o_gt/o_eq just updated
  logic busy;       // high while operand bits are being accepted

  modport master (
    output start, bit_valid, x_bit, y_bit,
    input  o_gt, o_eq, done, busy
  );

  modport slave (
    input  start, bit_valid, x_bit, y_bit,
    output o_gt, o_eq, done, busy
  );
endinterface
`default_nettype wire

// File: rtl/serial_magnitude_comparator.sv
`default_nettype none
// ============================================================================
// Module   : serial_magnitude_comparator
// Purpose  : Compares two unsigned WIDTH-bit operands presented serially,
//            MSB first, one bit pair per valid cycle. The first differing
//            pair decides the result; all WIDTH pairs are always consumed.
// Ports    : clk   - clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - slave modport: start, bit_valid, x_bit, y_bit in;
//                    o_gt, o_eq, done, busy out (all outputs registered)
// Revision : 1.0 - initial release
// ============================================================================
module serial_magnitude_comparator #(
  parameter int WIDTH = 4  // operand bits per comparison, 2..16
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  serial_magnitude_comparator_if.slave bus
);

  localparam int c_cnt_w = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_undecided;
  logic               r_gt;
  logic               r_o_gt;
  logic               r_o_eq;
  logic               r_done;
  logic               r_busy;

  // Decision logic for the pair presented this cycle. Once decided, the
  // flags are frozen because w_decide can no longer fire.
  logic w_differ;
  logic w_decide;
  logic w_undecided_nxt;
  logic w_gt_nxt;
  logic w_last;

  assign w_differ        = bus.x_bit ^ bus.y_bit;
  assign w_decide        = r_undecided & w_differ;
  assign w_undecided_nxt = r_undecided & ~w_differ;
  assign w_gt_nxt        = w_decide ? bus.x_bit : r_gt;
  assign w_last          = (r_cnt == c_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_undecided <= 1'b0;
      r_gt        <= 1'b0;
      r_o_gt      <= 1'b0;
      r_o_eq      <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // bit_valid is deliberately ignored here, even alongside start.
          if (bus.start) begin
            r_state     <= ST_SHIFT;
            r_cnt       <= '0;
            r_undecided <= 1'b1;
            r_gt        <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        ST_SHIFT: begin
          // start is ignored while shifting; stalls hold all state.
          if (bus.bit_valid) begin
            r_cnt       <= r_cnt + 1'b1;
            r_undecided <= w_undecided_nxt;
            r_gt        <= w_gt_nxt;
            if (w_last) begin
              // Results load from the next-state flags so the final pair
              // is included in the same edge that ends the comparison.
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_o_gt  <= w_gt_nxt;
              r_o_eq  <= w_undecided_nxt;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_gt = r_o_gt;
  assign bus.o_eq = r_o_eq;
  assign bus.done = r_done;
  assign bus.busy = r_busy;

endmodule
`default_nettype wire
